mio_bus_arbiter: RTL and testbench

- Shares the single memory/IO bus port between two masters. M0 is the multicycle CPU; M1 is a secondary requester such as a display fetcher or DMA engine.
- Grants one master at a time, latches its request, and drives the slave bus until the slave's ready handshake arrives.
- Returns read data and a one-cycle ready pulse to the granted master, with timeout and error reporting.
- Sits between the CPU top level and the memory/peripheral decoder.

---
 rtl/mio_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter for the shared memory/IO bus: grants one master at a time,
// holds the latched request on the slave port until s_ready or timeout, and returns a ready pulse.
module mio_bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          m1_err,
  output logic          s_req,
  output logic          s_we,
  output logic          mem_w,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,
  output logic [1:0]    grant,
  output logic [1:0]    state
);

  // Handshake: a master holds req until its one-cycle ready; ready with err=1 marks a timeout.
  // The slave side holds s_req with stable we/addr/wdata until s_ready is sampled high.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;     // 1 = M1 was served last
  logic            s_req_d, s_we_d;
  logic [AW-1:0]   s_addr_d;
  logic [DW-1:0]   s_wdata_d;
  logic [1:0]      grant_d;
  logic [DW-1:0]   m0_rdata_d, m1_rdata_d;
  logic            m0_ready_d, m1_ready_d, m0_err_d, m1_err_d;
  logic            elig0, elig1, pick1, sel1;

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    s_req_d    = s_req;
    s_we_d     = s_we;
    s_addr_d   = s_addr;
    s_wdata_d  = s_wdata;
    grant_d    = grant;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    // A master whose ready is high is about to drop req, so it must not be re-granted.
    elig0 = m0_req & ~m0_ready;
    elig1 = m1_req & ~m1_ready;
    pick1 = elig1 & (~elig0 | (!FIXED_PRIO && !last_q));
    sel1  = (state_q == BUSY1);

    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          s_req_d   = 1'b1;
          s_we_d    = pick1 ? m1_we : m0_we;
          s_addr_d  = pick1 ? m1_addr : m0_addr;
          s_wdata_d = pick1 ? m1_wdata : m0_wdata;
          grant_d   = pick1 ? 2'b10 : 2'b01;
          state_d   = pick1 ? BUSY1 : BUSY0;
          cnt_d     = '0;
        end
      end
      BUSY0, BUSY1: begin
        if (s_ready || (TIMEOUT != 0 && cnt_q == CNT_LAST)) begin
          if (sel1) begin
            m1_ready_d = 1'b1;
            m1_err_d   = ~s_ready;
            m1_rdata_d = (s_ready && !s_we) ? s_rdata : '0;
          end else begin
            m0_ready_d = 1'b1;
            m0_err_d   = ~s_ready;
            m0_rdata_d = (s_ready && !s_we) ? s_rdata : '0;
          end
          s_req_d = 1'b0;
          s_we_d  = 1'b0;
          grant_d = 2'b00;
          last_d  = sel1;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      mem_w    <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      grant    <= 2'b00;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      s_req    <= s_req_d;
      s_we     <= s_we_d;
      mem_w    <= s_req_d & s_we_d;
      s_addr   <= s_addr_d;
      s_wdata  <= s_wdata_d;
      grant    <= grant_d;
      m0_rdata <= m0_rdata_d;
      m1_rdata <= m1_rdata_d;
      m0_ready <= m0_ready_d;
      m1_ready <= m1_ready_d;
      m0_err   <= m0_err_d;
      m1_err   <= m1_err_d;
    end
  end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: a round-robin instance (dut) and a fixed-priority
// instance (fp) share stimulus; expected values are hand-derived per scenario.
module tb_mio_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, s_rdata = '0;
  logic          s_ready = 1'b0;

  logic [DW-1:0] m0_rdata, m1_rdata, fp_m0_rdata, fp_m1_rdata;
  logic          m0_ready, m0_err, m1_ready, m1_err;
  logic          fp_m0_ready, fp_m0_err, fp_m1_ready, fp_m1_err;
  logic          s_req, s_we, mem_w, fp_s_req, fp_s_we, fp_mem_w;
  logic [AW-1:0] s_addr, fp_s_addr;
  logic [DW-1:0] s_wdata, fp_s_wdata;
  logic [1:0]    grant, state, fp_grant, fp_state;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mio_bus_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .mem_w(mem_w), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant(grant), .state(state)
  );

  mio_bus_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1), .TIMEOUT(4)) fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(fp_m0_rdata), .m0_ready(fp_m0_ready), .m0_err(fp_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(fp_m1_rdata), .m1_ready(fp_m1_ready), .m1_err(fp_m1_err),
    .s_req(fp_s_req), .s_we(fp_s_we), .mem_w(fp_mem_w), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .grant(fp_grant), .state(fp_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    // Reset state
    do_reset();
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_sreq", {31'd0, s_req}, 32'd0);
    check("rst_memw", {31'd0, mem_w}, 32'd0);
    check("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);

    // Single M0 read, slave answers in the first BUSY cycle
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010;
    step();
    check("rd_grant", {30'd0, grant}, 32'd1);
    check("rd_state", {30'd0, state}, 32'd1);
    check("rd_sreq", {31'd0, s_req}, 32'd1);
    check("rd_saddr", s_addr, 32'h0000_0010);
    check("rd_memw", {31'd0, mem_w}, 32'd0);
    s_ready = 1; s_rdata = 32'hDEAD_BEEF;
    step();
    check("rd_ready", {31'd0, m0_ready}, 32'd1);
    check("rd_err", {31'd0, m0_err}, 32'd0);
    check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
    check("rd_m1_ready", {31'd0, m1_ready}, 32'd0);
    check("rd_idle", {30'd0, state}, 32'd0);
    m0_req = 0; s_ready = 0; s_rdata = 32'h0;
    step();
    check("rd_pulse_end", {31'd0, m0_ready}, 32'd0);
    check("rd_hold", m0_rdata, 32'hDEAD_BEEF);

    // Tie after M0 was served: round-robin picks M1, fixed priority picks M0
    m0_req = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    step();
    check("tie_rr_grant", {30'd0, grant}, 32'd2);
    check("tie_fp_grant", {30'd0, fp_grant}, 32'd1);
    s_ready = 1; s_rdata = 32'h55;
    step();
    check("tie_rr_m1rd", m1_rdata, 32'h55);
    check("tie_fp_m0rd", {31'd0, fp_m0_ready}, 32'd1);
    m0_req = 0; m1_req = 0; s_ready = 0;
    step();
    do_reset();

    // M1 write with slave delay; master inputs change while BUSY
    m1_req = 1; m1_we = 1; m1_addr = 32'hE000_0000; m1_wdata = 32'h1234_5678;
    step();
    check("wr_grant", {30'd0, grant}, 32'd2);
    check("wr_state", {30'd0, state}, 32'd2);
    check("wr_memw", {31'd0, mem_w}, 32'd1);
    m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'hAAAA_AAAA; m1_we = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("wr_saddr", s_addr, 32'hE000_0000);
      check("wr_swdata", s_wdata, 32'h1234_5678);
      check("wr_memw_busy", {31'd0, mem_w}, 32'd1);
      check("wr_no_ready", {31'd0, m1_ready}, 32'd0);
    end
    s_ready = 1; s_rdata = 32'hCAFE_0000;
    step();
    check("wr_ready", {31'd0, m1_ready}, 32'd1);
    check("wr_err", {31'd0, m1_err}, 32'd0);
    check("wr_rdata", m1_rdata, 32'd0);
    check("wr_memw_done", {31'd0, mem_w}, 32'd0);
    m1_req = 0; s_ready = 0;
    step();

    // Continuous contention: alternating grants with one IDLE cycle between them
    m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_grant", {30'd0, grant}, {30'd0, exp_g[k]});
      s_ready = 1; s_rdata = 32'h100 + k;
      step();
      check("rr_ready", {30'd0, m1_ready, m0_ready}, {30'd0, exp_g[k]});
      check("rr_idle", {30'd0, state}, 32'd0);
      s_ready = 0;
    end
    check("rr_m1_rdata", m1_rdata, 32'h103);
    check("rr_m0_rdata", m0_rdata, 32'h102);
    m0_req = 0; m1_req = 0;
    step();

    // Timeout: slave silent on an M0 read, then M1 is served
    m0_req = 1; m0_we = 0; m0_addr = 32'h30;
    step();
    check("to_grant", {30'd0, grant}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("to_wait_ready", {31'd0, m0_ready}, 32'd0);
      check("to_wait_state", {30'd0, state}, 32'd1);
    end
    step();
    check("to_ready", {31'd0, m0_ready}, 32'd1);
    check("to_err", {31'd0, m0_err}, 32'd1);
    check("to_rdata", m0_rdata, 32'd0);
    check("to_sreq", {31'd0, s_req}, 32'd0);
    check("to_m1_quiet", {30'd0, m1_err, m1_ready}, 32'd0);
    m0_req = 0; m1_req = 1; m1_we = 0;
    step();
    check("to_err_clear", {31'd0, m0_err}, 32'd0);
    check("to_m1_grant", {30'd0, grant}, 32'd2);
    s_ready = 1; s_rdata = 32'hA5A5;
    step();
    check("to_m1_ready", {31'd0, m1_ready}, 32'd1);
    check("to_m1_rdata", m1_rdata, 32'hA5A5);
    m1_req = 0; s_ready = 0;
    step();

    // Reset in the second BUSY1 cycle aborts without a ready pulse
    m1_req = 1; m1_we = 1; m1_addr = 32'h40;
    step();
    step();
    check("ab_busy", {30'd0, state}, 32'd2);
    reset = 1;
    step();
    check("ab_sreq", {31'd0, s_req}, 32'd0);
    check("ab_grant", {30'd0, grant}, 32'd0);
    check("ab_state", {30'd0, state}, 32'd0);
    check("ab_out", {29'd0, mem_w, m1_ready, m1_err}, 32'd0);
    reset = 0; m0_req = 1; m0_we = 0;
    step();
    check("ab_m0_first", {30'd0, grant}, 32'd1);
    check("ab_no_m1", {31'd0, m1_ready}, 32'd0);
    s_ready = 1; s_rdata = 32'h9;
    step();
    check("ab_m0_ready", {31'd0, m0_ready}, 32'd1);
    m0_req = 0; m1_req = 0; s_ready = 0;
    step();

    // M0 drops req while BUSY; transaction still completes once
    m0_req = 1; m0_we = 0; m0_addr = 32'h80;
    step();
    check("dr_grant", {30'd0, grant}, 32'd1);
    m0_req = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("dr_sreq", {31'd0, s_req}, 32'd1);
    end
    s_ready = 1; s_rdata = 32'h77;
    step();
    check("dr_ready", {31'd0, m0_ready}, 32'd1);
    check("dr_rdata", m0_rdata, 32'h77);
    s_ready = 0;
    step();
    check("dr_no_regrant", {30'd0, grant}, 32'd0);
    check("dr_sreq_low", {31'd0, s_req}, 32'd0);

    // s_ready in IDLE is ignored
    s_ready = 1; s_rdata = 32'h1;
    step();
    check("idle_sready", {30'd0, m1_ready, m0_ready}, 32'd0);
    check("idle_rdata", m0_rdata, 32'h77);
    s_ready = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
